// File: rtl/nios_sd_loader_irq_sched_if.sv
// rtl/nios_sd_loader_irq_sched_if.sv - Avalon-MM register bus bundle for the IRQ scheduler
// Signals: address[1:0], chipselect, write, writedata[31:0] (master -> slave),
//          readdata[31:0] (slave -> master, registered in the slave).
interface nios_sd_loader_irq_sched_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_sd_loader_irq_sched.sv
// rtl/nios_sd_loader_irq_sched.sv - round-robin interrupt scheduler with edge/level sources
// Ports: clk, reset_n (async active-low), in_port[3:0] raw async sources,
//        bus (slave modport: address/chipselect/write/writedata in, readdata out),
//        irq registered interrupt request to the CPU.
// Registers: 0 STATUS {pending,sync}, 1 CONFIG {edge,mask}, 2 VECTOR {valid,grant_id}, 3 ACK.
module nios_sd_loader_irq_sched #(
    parameter int NSRC = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NSRC-1:0]              in_port,
    nios_sd_loader_irq_sched_if.slave    bus,
    output logic                         irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  sync1, sync, sync_d;
    logic [3:0]  pending, pending_nxt;
    logic [3:0]  mask, edge_mode;
    logic [1:0]  grant_id, grant_nxt;
    logic [1:0]  last_id, last_nxt;
    logic [3:0]  eligible, rise, ack_clr;
    logic        cfg_wr, ack_wr;
    logic        rr_found;
    logic [1:0]  rr_id, rr_idx;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign unused_wdata = ^bus.writedata[31:8];

    assign rise     = sync & ~sync_d;
    assign eligible = pending & mask;
    assign cfg_wr   = bus.chipselect & bus.write & (bus.address == 2'd1);
    assign ack_wr   = bus.chipselect & bus.write & (bus.address == 2'd3);

    // Next-state, round-robin pick and ACK-driven pending clear.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_id;
        ack_clr   = '0;
        rr_found  = 1'b0;
        rr_id     = last_id;
        rr_idx    = '0;
        // Search starts one past the last acknowledged source and wraps.
        for (int k = 1; k <= 4; k++) begin
            rr_idx = last_id + 2'(k);
            if (!rr_found && eligible[rr_idx]) begin
                rr_found = 1'b1;
                rr_id    = rr_idx;
            end
        end
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt = rr_id;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (ack_wr) begin
                    ack_clr[grant_id] = edge_mode[grant_id];
                    last_nxt          = grant_id;
                    state_nxt         = HOLD;
                end else if (!eligible[grant_id]) begin
                    state_nxt = IDLE;
                end
            end
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Edge sources latch until acknowledged; a rise in the ACK cycle wins.
    always_comb begin
        pending_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            if (edge_mode[i])
                pending_nxt[i] = rise[i] | (pending[i] & ~ack_clr[i]);
            else
                pending_nxt[i] = sync[i];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            2'd0:    rd_mux = {24'b0, pending, sync};
            2'd1:    rd_mux = {24'b0, edge_mode, mask};
            2'd2:    rd_mux = {(state == GRANT), 29'b0, grant_id};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= '0;
            sync         <= '0;
            sync_d       <= '0;
            pending      <= '0;
            mask         <= '0;
            edge_mode    <= '0;
            state        <= IDLE;
            grant_id     <= '0;
            last_id      <= 2'd3;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            sync1        <= in_port;
            sync         <= sync1;
            sync_d       <= sync;
            pending      <= pending_nxt;
            if (cfg_wr) begin
                mask      <= bus.writedata[3:0];
                edge_mode <= bus.writedata[7:4];
            end
            state        <= state_nxt;
            grant_id     <= grant_nxt;
            last_id      <= last_nxt;
            // High one cycle after GRANT entry, low as soon as GRANT is left.
            irq          <= (state == GRANT) && (state_nxt == GRANT);
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_nios_sd_loader_irq_sched.sv
// tb/tb_nios_sd_loader_irq_sched.sv - self-checking bench for nios_sd_loader_irq_sched
module tb_nios_sd_loader_irq_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] in_port = '0;
    logic       irq;

    nios_sd_loader_irq_sched_if bus();

    nios_sd_loader_irq_sched #(.NSRC(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus.slave),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cfg;
        logic [3:0] pulse;
        int         n;
        logic [7:0] ids;
    } vec_t;

    vec_t       vecs[6];
    logic [1:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        @(negedge clk);
        d              = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_irq(input int budget, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (irq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: irq stayed 0 for %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic pulse_in(input logic [3:0] p);
        @(negedge clk);
        in_port = p;
        repeat (2) @(negedge clk);
        in_port = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [7:0] mk(input logic [1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    logic [31:0] rd;
    bit          ok;
    int          n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hFF, 4'b1011, 3, mk(2'd0, 2'd1, 2'd3, 2'd0)};
        vecs[1] = '{8'hFF, 4'b0001, 1, mk(2'd0, 2'd0, 2'd0, 2'd0)};
        vecs[2] = '{8'hFF, 4'b1111, 4, mk(2'd1, 2'd2, 2'd3, 2'd0)};
        vecs[3] = '{8'hF5, 4'b1111, 2, mk(2'd2, 2'd0, 2'd0, 2'd0)};
        vecs[4] = '{8'hFF, 4'b0000, 2, mk(2'd1, 2'd3, 2'd0, 2'd0)};
        vecs[5] = '{8'hFF, 4'b0100, 1, mk(2'd2, 2'd0, 2'd0, 2'd0)};

        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(2'd1, rd); check("reset_config", rd, 32'h0);
        bus_read(2'd0, rd); check("reset_status", rd, 32'h0);
        bus_read(2'd2, rd); check("reset_vector", rd, 32'h0);

        // Edge latency on source 2, 3-cycle input pulse
        bus_write(2'd1, 32'h0000_00FF);
        bus_read(2'd1, rd); check("config_rb", rd, 32'h0000_00FF);
        in_port = 4'b0100;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) in_port = '0;
            if (irq === 1'b1) begin
                n = c;
                break;
            end
        end
        check("edge_latency", n, 5);
        bus_read(2'd2, rd); check("vector_src2", rd, 32'h8000_0002);
        bus_read(2'd0, rd); check("status_pend2", rd, 32'h0000_0040);
        bus_write(2'd3, 32'h0);
        check("irq_after_ack", {31'b0, irq}, 32'h0);
        bus_read(2'd0, rd); check("status_cleared", rd, 32'h0);

        // Round-robin table with a grant scoreboard
        do_reset();
        for (int v = 0; v < 6; v++) begin
            bus_write(2'd1, {24'b0, vecs[v].cfg});
            pulse_in(vecs[v].pulse);
            for (int k = 0; k < vecs[v].n; k++)
                exp_q.push_back(vecs[v].ids[2*k +: 2]);
            while (exp_q.size() > 0) begin
                wait_irq(30, $sformatf("rr_grant_v%0d", v), ok);
                if (!ok) begin
                    exp_q.delete();
                    break;
                end
                bus_read(2'd2, rd);
                check($sformatf("rr_vector_v%0d", v), rd, {1'b1, 29'b0, exp_q.pop_front()});
                bus_write(2'd3, 32'h0);
                check($sformatf("rr_irq_low_v%0d", v), {31'b0, irq}, 32'h0);
            end
            repeat (12) @(negedge clk);
            check($sformatf("rr_no_extra_v%0d", v), {31'b0, irq}, 32'h0);
        end

        // Level source 1: re-grant after HOLD while held, drop mid-GRANT
        bus_write(2'd1, 32'h0000_000F);
        in_port = 4'b0010;
        wait_irq(30, "lvl_grant", ok);
        bus_read(2'd2, rd); check("lvl_vector", rd, 32'h8000_0001);
        bus_write(2'd3, 32'h0);
        check("lvl_irq_hold", {31'b0, irq}, 32'h0);
        wait_irq(30, "lvl_regrant", ok);
        bus_read(2'd2, rd); check("lvl_vector2", rd, 32'h8000_0001);
        in_port = '0;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (irq === 1'b0) begin
                n = c;
                break;
            end
        end
        check("lvl_drop_lat", n, 4);
        bus_read(2'd2, rd); check("lvl_vector_idle", rd, 32'h0000_0001);

        // Mask cleared during GRANT of edge source 2
        bus_write(2'd1, 32'h0000_00FF);
        pulse_in(4'b0100);
        wait_irq(30, "mask_grant", ok);
        bus_read(2'd2, rd); check("mask_vector", rd, 32'h8000_0002);
        bus_write(2'd1, 32'h0000_00F0);
        @(negedge clk);
        check("mask_irq_low", {31'b0, irq}, 32'h0);
        bus_read(2'd0, rd); check("mask_pend_kept", rd, 32'h0000_0040);
        bus_read(2'd2, rd); check("mask_vector_idle", rd, 32'h0000_0002);
        bus_write(2'd1, 32'h0000_00FF);
        wait_irq(30, "mask_regrant", ok);
        bus_read(2'd2, rd); check("mask_vector2", rd, 32'h8000_0002);
        bus_write(2'd3, 32'h0);

        // New edge on source 0 in the same cycle as its ACK
        pulse_in(4'b0001);
        wait_irq(30, "race_grant", ok);
        bus_read(2'd2, rd); check("race_vector", rd, 32'h8000_0000);
        in_port = 4'b0001;
        @(negedge clk);
        bus_write(2'd3, 32'h0);
        check("race_irq_low", {31'b0, irq}, 32'h0);
        bus_read(2'd0, rd); check("race_pend_kept", rd, 32'h0000_0011);
        in_port = '0;
        wait_irq(30, "race_regrant", ok);
        bus_read(2'd2, rd); check("race_vector2", rd, 32'h8000_0000);
        bus_write(2'd3, 32'h0);
        repeat (2) @(negedge clk);
        bus_read(2'd0, rd); check("race_status_clr", rd, 32'h0);

        // ACK while IDLE is ignored
        bus_write(2'd1, 32'h0000_00F0);
        pulse_in(4'b0001);
        repeat (4) @(negedge clk);
        bus_write(2'd3, 32'h0);
        bus_read(2'd0, rd); check("idle_ack_pend", rd, 32'h0000_0010);
        bus_read(2'd2, rd); check("idle_ack_vector", rd, 32'h0);
        check("idle_ack_irq", {31'b0, irq}, 32'h0);

        // Reset asserted mid-GRANT
        bus_write(2'd1, 32'h0000_00FF);
        wait_irq(30, "rst_grant", ok);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_readdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, rd); check("rst_config", rd, 32'h0);
        bus_read(2'd0, rd); check("rst_status", rd, 32'h0);
        repeat (10) @(negedge clk);
        check("rst_irq_stays", {31'b0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_sd_loader_irq_sched.md
NIOS_SD_LOADER_IRQ_SCHED -- requirements
Module: nios_sd_loader_irq_sched

Interface
REQ-001 Parameter: NSRC, 4, number of interrupt sources; fixed at 4 for this block.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_port  input  4  raw interrupt sources, asynchronous to clk.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select; qualifies read and write.
REQ-007 write  input  1  write strobe, single cycle.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data.
REQ-010 irq  output  1  interrupt request to CPU, registered.

Function
REQ-011 in_port SHALL pass a 2-flop synchronizer (sync) plus a 1-flop delay (sync_d) per bit.
REQ-012 Register map SHALL be: 0 STATUS (RO), 1 CONFIG (RW), 2 VECTOR (RO), 3 ACK (WO).
REQ-013 STATUS SHALL read {24'b0, pending[3:0], sync[3:0]}.
REQ-014 CONFIG SHALL hold mask[3:0] in bits 3:0 (1 = enabled) and edge[3:0] in bits 7:4 (1 = rising-edge, 0 = level); bits 31:8 read 0.
REQ-015 VECTOR SHALL read {valid, 29'b0, grant_id[1:0]}; valid = 1 only in state GRANT.
REQ-016 ACK reads and all unmapped bits SHALL return 0.
REQ-017 readdata SHALL update every cycle from the mux at address, one-cycle latency, independent of chipselect.
REQ-018 Edge source: pending[i] SHALL set on the cycle after sync[i] & ~sync_d[i]; cleared only by ACK of that source.
REQ-019 Level source: pending[i] SHALL equal sync[i] registered each cycle; ACK has no effect on it.
REQ-020 Eligible vector SHALL be pending & mask.
REQ-021 FSM states SHALL be IDLE, GRANT, HOLD.
REQ-022 IDLE: if eligible != 0, SHALL select grant_id round-robin (search starts at last_id+1 mod 4, wraps 3->0), go to GRANT; else stay.
REQ-023 GRANT: irq = 1; on ACK write (chipselect & write & address==3) SHALL clear pending[grant_id] if edge mode, record last_id = grant_id, go to HOLD.
REQ-024 GRANT: if eligible[grant_id] falls to 0 without ACK (mask cleared or level source dropped), SHALL return to IDLE, irq = 0, last_id unchanged.
REQ-025 HOLD: irq = 0 for exactly one cycle, then IDLE (guarantees irq deassertion between grants).
REQ-026 irq SHALL be registered: high from the cycle after entry into GRANT through the cycle of exit.
REQ-027 New edge on grant_id in the same cycle as its ACK: set SHALL win; pending stays 1.
REQ-028 ACK write outside GRANT SHALL be ignored.
REQ-029 CONFIG writes SHALL take effect next cycle, in any state; grant_id SHALL not change while in GRANT.
REQ-030 Input rise to irq high latency (edge mode, idle, enabled) SHALL be 5 cycles: sync 2, detect/pending 1, FSM 1, irq register 1.

Reset
REQ-031 On reset_n low, SHALL asynchronously clear sync, sync_d, pending, mask, edge, last_id (=3, so first search starts at 0), grant_id, readdata, irq; state = IDLE.
REQ-032 Reset asserted mid-GRANT SHALL drop irq immediately with no ACK required; after release, outstanding edges are lost.

Verification
REQ-033 CONFIG=0x0000_00FF, pulse in_port[2] 3 cycles -> irq high 5 cycles after rise; VECTOR reads 0x8000_0002; ACK -> irq low next cycle, STATUS pending[2]=0.
REQ-034 CONFIG=0xFF, edges on sources 0,1,3 simultaneously -> grants in order 0,1,3 with one HOLD cycle of irq=0 between; then edge on 0 -> grant 0 after wrap.
REQ-035 CONFIG=0x0F (all level), hold in_port[1]=1 -> grant 1; ACK -> HOLD, re-grant 1 while high; drop in_port[1] during GRANT -> IDLE, irq=0 within 4 cycles.
REQ-036 In GRANT for source 2 (edge), write CONFIG=0xF0 -> next cycle IDLE, irq=0, pending[2] still 1; re-enable CONFIG=0xFF -> re-grant 2.
REQ-037 New edge on source 0 in the ACK cycle of source 0 -> pending[0] stays 1, re-grant 0 after HOLD; ACK while IDLE -> no state change.
REQ-038 Assert reset_n low mid-GRANT -> irq=0, readdata=0, CONFIG reads 0 after release.
